et_sng: RTL and testbench

- Early-terminating stochastic number generator. Sits directly downstream of the progressive-precision block.
- Takes the N binary operands together with the per-group bit-position masks S and the stream length k_init produced for them. Emits N weighted-binary bitstreams, one bit per operand per cycle.
- Stops after k_init bits, so the downstream SC datapath terminates early.

---
 rtl/et_sng_pkg.sv | 7 +
 rtl/et_sng_sel_gen.sv | 21 ++
 rtl/et_sng.sv | 68 ++++++
 tb/tb_et_sng.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/et_sng_pkg.sv
// et_sng_pkg: shared FSM state encoding and stream counter width helper for et_sng
package et_sng_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2((1 << w) + 1);
  endfunction
endpackage

// File: rtl/et_sng_sel_gen.sv
// et_sng_sel_gen: trailing-zero count of cnt decoded to MSB-first one-hot sel (sel=0 once cnt=2^W); in cnt, out sel
module et_sng_sel_gen
  import et_sng_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = cnt_w(W)
) (
  input  logic [CW-1:0] cnt,
  output logic [W-1:0]  sel
);
  localparam int TW = $clog2(CW + 1);
  logic [TW-1:0] t;
  always_comb begin
    t = TW'(CW);
    for (int i = CW - 1; i >= 0; i--) t = cnt[i] ? TW'(i) : t;
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < W; i++) sel[i] = t == TW'(W - 1 - i);
  end
endmodule

// File: rtl/et_sng.sv
// et_sng: early-terminating SNG; in start/Bxs/S/k_init/bs_ready, out bs/bs_valid/bs_last/busy/done, sync active-low rst_n
module et_sng
  import et_sng_pkg::*;
#(
  parameter int W        = 8,
  parameter int N        = 2,
  parameter int S_GROUPS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N-1:0][W-1:0]          Bxs,
  input  logic [S_GROUPS-1:0][W-1:0]   S,
  input  logic [W-1:0]                 k_init,
  output logic [N-1:0]                 bs,
  output logic                         bs_valid,
  input  logic                         bs_ready,
  output logic                         bs_last,
  output logic                         busy,
  output logic                         done
);
  localparam int CW = cnt_w(W);
  if (S_GROUPS != 1 && S_GROUPS != N) begin : g_bad_groups
    $error("et_sng: S_GROUPS must be 1 or N");
  end
  state_t                       state;
  logic [N-1:0][W-1:0]          bxr;
  logic [S_GROUPS-1:0][W-1:0]   sr;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                rem;
  logic [W-1:0]                 sel;
  assign bs_valid = state == RUN;
  assign busy     = state == RUN;
  assign done     = state == DONE;
  assign bs_last  = bs_valid && rem == CW'(1);
  et_sng_sel_gen #(.W(W), .CW(CW)) u_sel (
    .cnt(cnt),
    .sel(sel)
  );
  for (genvar j = 0; j < N; j++) begin : g_bs
    assign bs[j] = bs_valid & |(bxr[j] & sr[S_GROUPS == 1 ? 0 : j] & sel);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bxr   <= '0;
      sr    <= '0;
      cnt   <= '0;
      rem   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        bxr   <= Bxs;
        sr    <= S;
        cnt   <= CW'(1);
        rem   <= k_init == '0 ? CW'(1) << W : CW'(k_init);
      end
    end else if (state == RUN) begin
      if (bs_ready) begin
        cnt <= cnt + CW'(1);
        rem <= rem - CW'(1);
        if (rem == CW'(1)) state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_et_sng.sv
// tb_et_sng: randomized scoreboard bench for et_sng against a trailing-zero arithmetic reference model
module tb_et_sng;
  localparam int W = 4, N = 2, SG = 2;
  logic clk = 0, rst_n = 0, start = 0, bs_ready = 0;
  logic [N-1:0][W-1:0] bxs = '0;
  logic [SG-1:0][W-1:0] s = '0;
  logic [W-1:0] k_init = '0;
  logic [N-1:0] bs;
  logic bs_valid, bs_last, busy, done;
  int checks = 0, errors = 0, ones0 = 0, ones1 = 0;
  typedef struct packed {logic [N-1:0] b; logic l;} exp_t;
  exp_t q[$];

  et_sng #(.W(W), .N(N), .S_GROUPS(SG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Bxs(bxs), .S(s), .k_init(k_init),
    .bs(bs), .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_last(bs_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic ref_bit(input logic [W-1:0] b, input logic [W-1:0] m, input int idx);
    int t = 0;
    while (idx % 2 == 0) begin
      idx = idx / 2;
      t++;
    end
    return t < W ? b[W-1-t] & m[W-1-t] : 1'b0;
  endfunction

  initial begin
    logic [N-1:0] pbs = '0;
    logic pl = 0, pstall = 0, plast = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 0;
        plast = 0;
      end else begin
        if (pstall) begin
          chk("stall_bs", bs, pbs);
          chk("stall_last", bs_last, pl);
          chk("stall_valid", bs_valid, 1);
        end
        if (plast) chk("done_pulse", done, 1);
        else if (done) chk("done_spurious", done, 0);
        if (bs_valid && bs_ready) begin
          if (q.size() == 0) chk("unexpected_bit", bs_valid, 0);
          else begin
            e = q.pop_front();
            chk("bs", bs, e.b);
            chk("bs_last", bs_last, e.l);
            ones0 += int'(bs[0]);
            ones1 += int'(bs[1]);
          end
        end
        pstall = bs_valid && !bs_ready;
        pbs = bs;
        pl = bs_last;
        plast = bs_valid && bs_ready && bs_last;
      end
    end
  end

  task automatic stream(input logic [W-1:0] b0, b1, s0, s1, k, input int mode, input bit disturb);
    int kk = k == '0 ? (1 << W) : int'(k);
    int cyc = 0, bcyc = 0;
    ones0 = 0;
    ones1 = 0;
    for (int i = 1; i <= kk; i++) q.push_back({ref_bit(b1, s1, i), ref_bit(b0, s0, i), i == kk});
    bxs[0] = b0; bxs[1] = b1; s[0] = s0; s[1] = s1; k_init = k;
    start = 1;
    bs_ready = 0;
    @(posedge clk); #1;
    start = 0;
    bxs = (N*W)'($urandom); s = (SG*W)'($urandom); k_init = W'($urandom);
    chk("first_valid", bs_valid, 1);
    while (!done && cyc < 1000) begin
      if (busy) bcyc++;
      bs_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 1) : 1'($urandom);
      start = disturb && cyc == 3;
      if (start) bxs = (N*W)'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    if (!done) chk("stream_timeout", done, 1);
    if (disturb) begin
      start = 1;
      bxs = (N*W)'($urandom);
      k_init = 4'd1;
    end
    @(posedge clk); #1;
    start = 0;
    chk("idle_after_done", {busy, done, bs_valid}, 0);
    if (mode == 0) chk("busy_cycles", bcyc, kk);
    if (mode == 1) chk("busy_cycles_bp", bcyc, 2 * kk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bs_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bs", {bs, bs_last}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    stream(4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'd0, 0, 0);
    chk("full_ones", ones0, 8);
    stream(4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'd2, 0, 0);
    chk("early_ones", ones0, 1);
    stream(4'b1111, 4'b1111, 4'b1100, 4'b0011, 4'd0, 0, 0);
    chk("mask_ones0", ones0, 12);
    chk("mask_ones1", ones1, 3);
    stream(4'b1000, 4'b0000, 4'b1111, 4'b0000, 4'd0, 1, 0);
    chk("bp_ones", ones0, 8);
    stream(4'b1010, 4'b0110, 4'b1111, 4'b1110, 4'd6, 0, 1);
    stream(4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'd0, 0, 0);
    for (int i = 1; i <= 5; i++) q.push_back({1'b0, ref_bit(4'b1111, 4'b1111, i), 1'b0});
    bxs[0] = 4'b1111; s[0] = 4'b1111; k_init = 4'd0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    bs_ready = 1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    q.delete();
    chk("midrst_valid", bs_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_nodone", done, 0);
    stream(4'b0101, 4'b1001, 4'b1111, 4'b1111, 4'd0, 0, 0);
    for (int n = 0; n < 10; n++)
      stream(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2, 1'($urandom));
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
